// File: rtl/sponge_absorb_ctrl.sv
// Sponge absorb controller: pads and XORs rate-sized blocks into a 1600-bit state and
// sequences an external Keccak-f[1600] core until the absorbed state is handed off.
module sponge_absorb_ctrl #(
  parameter int unsigned  RATE = 1088,
  parameter logic [7:0]   DS   = 8'h06,
  localparam int unsigned BW   = $clog2(RATE / 8 + 1),
  localparam int unsigned SW   = 1600
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            blk_valid_i,
  output logic            blk_ready_o,
  input  logic [RATE-1:0] blk_data_i,
  input  logic            blk_last_i,
  input  logic [BW-1:0]   blk_bytes_i,
  output logic            perm_start_o,
  output logic [SW-1:0]   perm_state_o,
  input  logic            perm_done_i,
  input  logic [SW-1:0]   perm_result_i,
  output logic            sponge_valid_o,
  input  logic            sponge_ready_i,
  output logic [SW-1:0]   sponge_state_o,
  output logic            busy_o
);

  localparam int unsigned     RB      = RATE / 8;
  localparam logic [BW-1:0]   RB_W    = BW'(RB);
  localparam logic [RATE-1:0] PAD_BLK = {8'h80, {(RATE - 16){1'b0}}, DS};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PERM,
    ST_WAIT,
    ST_PAD,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic            last_q, last_d;
  logic            pad_pend_q, pad_pend_d;
  logic            blk_ready_q, blk_ready_d;
  logic            perm_start_q, perm_start_d;
  logic            sponge_valid_q, sponge_valid_d;
  logic            busy_q, busy_d;
  logic [BW-1:0]   n_eff;
  logic [RATE-1:0] padded;

  // Oversized byte counts saturate to a full block
  always_comb begin
    n_eff = (blk_bytes_i > RB_W) ? RB_W : blk_bytes_i;
  end

  // pad10*1 on a short final block; a full final block passes through untouched
  always_comb begin
    padded = blk_data_i;
    if (blk_last_i) begin
      for (int unsigned k = 0; k < RB; k++) begin
        if (BW'(k) >= n_eff) padded[8*k +: 8] = 8'h00;
        if (BW'(k) == n_eff) padded[8*k +: 8] = padded[8*k +: 8] ^ DS;
      end
      if (n_eff != RB_W) padded[RATE-1 -: 8] = padded[RATE-1 -: 8] ^ 8'h80;
    end
  end

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (blk_valid_i) begin
          s_d[RATE-1:0] = s_q[RATE-1:0] ^ padded;
          last_d        = blk_last_i;
          pad_pend_d    = blk_last_i && (n_eff == RB_W);
          state_d       = ST_PERM;
        end
      end
      ST_PERM: state_d = ST_WAIT;
      ST_WAIT: begin
        if (perm_done_i) begin
          s_d = perm_result_i;
          if (pad_pend_q)  state_d = ST_PAD;
          else if (last_q) state_d = ST_DONE;
          else             state_d = ST_IDLE;
        end
      end
      ST_PAD: begin
        s_d[RATE-1:0] = s_q[RATE-1:0] ^ PAD_BLK;
        pad_pend_d    = 1'b0;
        state_d       = ST_PERM;
      end
      ST_DONE: begin
        if (sponge_ready_i) begin
          s_d     = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    blk_ready_d    = (state_d == ST_IDLE);
    perm_start_d   = (state_d == ST_PERM);
    sponge_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      s_q            <= '0;
      last_q         <= 1'b0;
      pad_pend_q     <= 1'b0;
      blk_ready_q    <= 1'b1;
      perm_start_q   <= 1'b0;
      sponge_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      last_q         <= last_d;
      pad_pend_q     <= pad_pend_d;
      blk_ready_q    <= blk_ready_d;
      perm_start_q   <= perm_start_d;
      sponge_valid_q <= sponge_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign blk_ready_o    = blk_ready_q;
  assign perm_start_o   = perm_start_q;
  assign sponge_valid_o = sponge_valid_q;
  assign busy_o         = busy_q;
  assign perm_state_o   = s_q;
  assign sponge_state_o = s_q;

endmodule
